// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back requesters, the register-file write port and decode read ports.
// Forwarding outputs exist only when RF_WB_FORWARD_EN is defined.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_BUS_WIDTH = 5,
    parameter int DATA_BUS_WIDTH = 32
);
    logic                      req0_valid;
    logic [ADDR_BUS_WIDTH-1:0] req0_addr;
    logic [DATA_BUS_WIDTH-1:0] req0_data;
    logic                      req0_ready;
    logic                      req1_valid;
    logic [ADDR_BUS_WIDTH-1:0] req1_addr;
    logic [DATA_BUS_WIDTH-1:0] req1_data;
    logic                      req1_ready;
    logic [ADDR_BUS_WIDTH-1:0] rf_addr3;
    logic [DATA_BUS_WIDTH-1:0] rf_write_data;
    logic                      rf_write_en;
    logic [ADDR_BUS_WIDTH-1:0] rd_addr1;
    logic [ADDR_BUS_WIDTH-1:0] rd_addr2;
    logic                      hazard1;
    logic                      hazard2;
    logic [15:0]               conflict_count;
`ifdef RF_WB_FORWARD_EN
    logic [DATA_BUS_WIDTH-1:0] fwd_data1;
    logic [DATA_BUS_WIDTH-1:0] fwd_data2;
`endif

`ifdef RF_WB_FORWARD_EN
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  rd_addr1, rd_addr2,
        output req0_ready, req1_ready, rf_addr3, rf_write_data, rf_write_en,
        output hazard1, hazard2, conflict_count, fwd_data1, fwd_data2
    );
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output rd_addr1, rd_addr2,
        input  req0_ready, req1_ready, rf_addr3, rf_write_data, rf_write_en,
        input  hazard1, hazard2, conflict_count, fwd_data1, fwd_data2
    );
`else
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  rd_addr1, rd_addr2,
        output req0_ready, req1_ready, rf_addr3, rf_write_data, rf_write_en,
        output hazard1, hazard2, conflict_count
    );
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output rd_addr1, rd_addr2,
        input  req0_ready, req1_ready, rf_addr3, rf_write_data, rf_write_en,
        input  hazard1, hazard2, conflict_count
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding a one-entry register-file write stage with hazard flags.
// Optional RF_WB_FORWARD_EN adds fwd_data1/fwd_data2 outputs mirroring the in-flight write data.
module regfile_wb_arbiter #(
    parameter int ADDR_BUS_WIDTH = 5,
    parameter int DATA_BUS_WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);
    logic                      prio;
    logic                      grant0;
    logic                      grant1;
    logic                      both_valid;
    logic [ADDR_BUS_WIDTH-1:0] wr_addr;
    logic [DATA_BUS_WIDTH-1:0] wr_data;
    logic                      wr_en;
    logic [15:0]               conflicts;

    // prio = 0 favours req0 when both are valid, 1 favours req1
    always_comb begin
        both_valid = bus.req0_valid && bus.req1_valid;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (rst_n) begin
            if (both_valid) begin
                grant0 = !prio;
                grant1 = prio;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            conflicts <= '0;
        end else begin
            if (grant0) begin
                wr_addr <= bus.req0_addr;
                wr_data <= bus.req0_data;
                wr_en   <= (bus.req0_addr != '0);
            end else if (grant1) begin
                wr_addr <= bus.req1_addr;
                wr_data <= bus.req1_data;
                wr_en   <= (bus.req1_addr != '0);
            end else begin
                wr_en   <= 1'b0;
            end
            if (both_valid) begin
                prio <= grant0;
                if (conflicts != 16'hFFFF) begin
                    conflicts <= conflicts + 16'd1;
                end
            end
        end
    end

    // wr_en is never set for register 0, so hazards on address 0 are impossible
    assign bus.req0_ready     = grant0;
    assign bus.req1_ready     = grant1;
    assign bus.rf_addr3       = wr_addr;
    assign bus.rf_write_data  = wr_data;
    assign bus.rf_write_en    = wr_en;
    assign bus.hazard1        = wr_en && (bus.rd_addr1 == wr_addr);
    assign bus.hazard2        = wr_en && (bus.rd_addr2 == wr_addr);
    assign bus.conflict_count = conflicts;

`ifdef RF_WB_FORWARD_EN
    assign bus.fwd_data1 = wr_data;
    assign bus.fwd_data2 = wr_data;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset and mid-write reset sequences.
// A small register-file model captures writes on the negedge to support readback checks.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] rf_model [32];

    regfile_wb_arbiter_if #(.ADDR_BUS_WIDTH(5), .DATA_BUS_WIDTH(32)) bus ();

    regfile_wb_arbiter #(.ADDR_BUS_WIDTH(5), .DATA_BUS_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file ignores writes while reset is held
    always @(negedge clk) begin
        if (rst_n && bus.rf_write_en) rf_model[bus.rf_addr3] <= bus.rf_write_data;
    end

    typedef struct {
        logic        r0v;
        logic [4:0]  r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1a;
        logic [31:0] r1d;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        rdy0;
        logic        rdy1;
        logic        wen;
        logic [4:0]  a3;
        logic [31:0] d;
        logic        hz1;
        logic        hz2;
        logic [15:0] cc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        bus.rd_addr1   = r1;
        bus.rd_addr2   = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;

        //         r0v   r0a    r0d            r1v   r1a    r1d           rd1    rd2    rdy0  rdy1  wen   a3     d              hz1   hz2   cc
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd3,  32'h33,      5'd3,  5'd1,  1'b1, 1'b0, 1'b1, 5'd1,  32'h11,       1'b0, 1'b1, 16'd1};
        vecs[2]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd3,  32'h33,      5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd3,  32'h33,       1'b0, 1'b0, 16'd2};
        vecs[3]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd4,  32'h44,      5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd2,  32'h22,       1'b0, 1'b0, 16'd3};
        vecs[4]  = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd4,  32'h44,      5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd4,  32'h44,       1'b0, 1'b0, 16'd4};
        vecs[5]  = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  32'h0,       5'd6,  5'd4,  1'b1, 1'b0, 1'b1, 5'd6,  32'h66,       1'b1, 1'b0, 16'd4};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,    5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 5'd0,  32'h1234,     1'b0, 1'b0, 16'd4};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99,      5'd9,  5'd10, 1'b0, 1'b1, 1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 16'd4};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd9,  5'd10, 1'b0, 1'b0, 1'b0, 5'd9,  32'h99,       1'b0, 1'b0, 16'd4};
        vecs[9]  = '{1'b1, 5'd12, 32'hAAAA,     1'b1, 5'd12, 32'hBBBB,    5'd0,  5'd12, 1'b1, 1'b0, 1'b1, 5'd12, 32'hAAAA,     1'b0, 1'b1, 16'd5};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hBBBB,    5'd12, 5'd0,  1'b0, 1'b1, 1'b1, 5'd12, 32'hBBBB,     1'b1, 1'b0, 16'd5};
        vecs[11] = '{1'b1, 5'd13, 32'h13,       1'b1, 5'd14, 32'h14,      5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 5'd14, 32'h14,       1'b0, 1'b0, 16'd6};
        vecs[12] = '{1'b1, 5'd13, 32'h13,       1'b0, 5'd0,  32'h0,       5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd13, 32'h13,       1'b0, 1'b0, 16'd6};

        // reset held 3 cycles with both requesters valid
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rst%0d rdy0", c), 32'(bus.req0_ready), 32'h0);
            chk($sformatf("rst%0d rdy1", c), 32'(bus.req1_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d wen", c), 32'(bus.rf_write_en), 32'h0);
            chk($sformatf("rst%0d cc", c), 32'(bus.conflict_count), 32'h0);
        end
        chk("rst addr3", 32'(bus.rf_addr3), 32'h0);
        chk("rst wdata", bus.rf_write_data, 32'h0);
        chk("rst hz1", 32'(bus.hazard1), 32'h0);
        chk("rst hz2", 32'(bus.hazard2), 32'h0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].r0v, vecs[i].r0a, vecs[i].r0d, vecs[i].r1v, vecs[i].r1a, vecs[i].r1d,
                  vecs[i].rd1, vecs[i].rd2);
            #1;
            chk($sformatf("v%0d rdy0", i), 32'(bus.req0_ready), 32'(vecs[i].rdy0));
            chk($sformatf("v%0d rdy1", i), 32'(bus.req1_ready), 32'(vecs[i].rdy1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wen", i), 32'(bus.rf_write_en), 32'(vecs[i].wen));
            chk($sformatf("v%0d addr3", i), 32'(bus.rf_addr3), 32'(vecs[i].a3));
            chk($sformatf("v%0d wdata", i), bus.rf_write_data, vecs[i].d);
            chk($sformatf("v%0d hz1", i), 32'(bus.hazard1), 32'(vecs[i].hz1));
            chk($sformatf("v%0d hz2", i), 32'(bus.hazard2), 32'(vecs[i].hz2));
            chk($sformatf("v%0d cc", i), 32'(bus.conflict_count), 32'(vecs[i].cc));
`ifdef RF_WB_FORWARD_EN
            chk($sformatf("v%0d fwd1", i), bus.fwd_data1, vecs[i].d);
            chk($sformatf("v%0d fwd2", i), bus.fwd_data2, vecs[i].d);
`endif
        end

        // reset right after a grant to reg 7: write cancelled, prio cleared
        drive(1'b1, 5'd7, 32'h777, 1'b1, 5'd8, 32'h888, 5'd7, 5'd0);
        #1;
        chk("mid rdy0", 32'(bus.req0_ready), 32'h1);
        chk("mid rdy1", 32'(bus.req1_ready), 32'h0);
        tick();
        chk("mid wen pre", 32'(bus.rf_write_en), 32'h1);
        chk("mid addr3 pre", 32'(bus.rf_addr3), 32'h7);
        rst_n = 1'b0;
        #1;
        chk("mid rst rdy0", 32'(bus.req0_ready), 32'h0);
        chk("mid rst rdy1", 32'(bus.req1_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("mid wen post", 32'(bus.rf_write_en), 32'h0);
        chk("mid addr3 post", 32'(bus.rf_addr3), 32'h0);
        chk("mid cc post", 32'(bus.conflict_count), 32'h0);
        chk("mid hz1 post", 32'(bus.hazard1), 32'h0);

        // first cycle after release with both valid: req0 wins
        rst_n = 1'b1;
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd8, 32'h888, 5'd0, 5'd0);
        #1;
        chk("rel rdy0", 32'(bus.req0_ready), 32'h1);
        chk("rel rdy1", 32'(bus.req1_ready), 32'h0);
        tick();
        chk("rel wen", 32'(bus.rf_write_en), 32'h1);
        chk("rel addr3", 32'(bus.rf_addr3), 32'd20);
        chk("rel wdata", bus.rf_write_data, 32'h20);
        chk("rel cc", 32'(bus.conflict_count), 32'h1);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        tick();

        chk("rb reg5", rf_model[5], 32'hDEADBEEF);
        chk("rb reg9", rf_model[9], 32'h99);
        chk("rb reg12", rf_model[12], 32'hBBBB);
        chk("rb reg0", rf_model[0], 32'h0);
        chk("rb reg7", rf_model[7], 32'h0);
        chk("rb reg8", rf_model[8], 32'h0);
        chk("rb reg20", rf_model[20], 32'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32-entry register file. Two requesters (ALU result path, load/memory result path) compete for the single register-file write port (addr3 / write_data / write_en). The block grants one requester per cycle round-robin, registers the winner into a one-entry write stage that drives the write port, and flags read addresses that hit the in-flight write. It drops writes to register 0.

## Interface
- ADDR_BUS_WIDTH, 5: register address width.
- DATA_BUS_WIDTH, 32: register data width.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 (ALU) has a write pending.
- req0_addr  in  ADDR_BUS_WIDTH  requester 0 destination register.
- req0_data  in  DATA_BUS_WIDTH  requester 0 write value.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as above for requester 1 (load path).
- rf_addr3  out  ADDR_BUS_WIDTH  to register-file write address.
- rf_write_data  out  DATA_BUS_WIDTH  to register-file write data.
- rf_write_en  out  1  to register-file write enable.
- rd_addr1, rd_addr2  in  ADDR_BUS_WIDTH  current decode read addresses.
- hazard1, hazard2  out  1  read address matches the in-flight write.
- conflict_count  out  16  saturating count of cycles with both requests valid.

## Operation
- Handshake: a transfer occurs on a posedge where reqN_valid && reqN_ready. Requesters hold addr/data stable while valid && !ready.
- reqN_ready is combinational. At most one is high. Both are forced 0 while rst_n is low.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by priority pointer prio is granted.
  - Neither valid: no grant.
- prio (1 bit, reset 0 = req0) moves to the non-granted requester after every grant made while both were valid. It is unchanged otherwise.
- Write stage: on a grant, the stage loads addr and data at the posedge. rf_write_en = 1 for exactly the next cycle, unless addr == 0, in which case rf_write_en = 0 (accepted, dropped).
- Without a grant, rf_write_en = 0 next cycle. rf_addr3 and rf_write_data hold their last values.
- The stage never back-pressures, because the register file accepts one write per cycle. Throughput is one write per cycle.
- hazardN = rf_write_en && (rd_addrN == rf_addr3), combinational. It is never asserted for address 0.
- Same-address requests in the same cycle: the loser is written one cycle after the winner. The last value written is the loser's.
- conflict_count increments on every cycle with req0_valid && req1_valid, and saturates at 16'hFFFF.

## Timing
- Reset values (after the first posedge with rst_n = 0): rf_write_en 0, rf_addr3 0, rf_write_data 0, prio 0, conflict_count 0, hazard1/2 0.
- Latency: request accepted at posedge T. rf_write_en is high during cycle T..T+1. The register file captures the write on the negedge inside that cycle, so the value is readable from cycle T+1 second half onward.
- Reset asserted mid-operation: an in-flight write is cancelled (rf_write_en 0 after that posedge). Pending requests are not accepted until rst_n returns high.
- First cycle after reset release with both valid: req0 wins.

## Configuration
- RF_WB_FORWARD_EN defined:
  - Adds outputs fwd_data1, fwd_data2 (DATA_BUS_WIDTH), each equal to rf_write_data.
  - hazardN then means "forward fwd_dataN in place of read_dataN".
- RF_WB_FORWARD_EN undefined:
  - The fwd ports do not exist.
  - hazardN means the decode stage must stall one cycle.
- Arbitration, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with both valid. Required: both readys 0, rf_write_en 0, conflict_count 0.
- Single requester: req0 valid with addr 5, data 32'hDEADBEEF for 1 cycle. Required: req0_ready = 1; next cycle rf_write_en = 1, rf_addr3 = 5, rf_write_data = 32'hDEADBEEF. A readback of reg 5 afterwards returns 32'hDEADBEEF.
- Round-robin: both valid continuously for 4 cycles (req0 addr 1/2, req1 addr 3/4). Required: grant order req0, req1, req0, req1; conflict_count = 4.
- Register 0: req1 writes addr 0, data 32'h1234. Required: req1_ready = 1, rf_write_en stays 0, hazard1 = 0 with rd_addr1 = 0.
- Hazard: write addr 9 accepted, with rd_addr1 = 9 and rd_addr2 = 10 in the following cycle. Required: hazard1 = 1, hazard2 = 0. With RF_WB_FORWARD_EN defined, fwd_data1 also equals the written data.
- Reset mid-write: assert rst_n = 0 the cycle after a grant to addr 7. Required: rf_write_en = 0 after that posedge, and reg 7 is unchanged.
